// File: rtl/fuzz_seq_pkg.sv
// Shared types, constants and helper functions for the fuzz vector sequencer.
package fuzz_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

  // Widest DUT output bus the fold helper accepts; narrower buses are
  // zero-extended by the caller, which also zero-pads the top chunk.
  localparam int FOLD_MAX_W = 1024;

  // XOR of all 32-bit chunks of the (zero-extended) DUT output bus.
  function automatic logic [31:0] fold(input logic [FOLD_MAX_W-1:0] bus);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < FOLD_MAX_W / 32; i++) begin
      acc = acc ^ bus[i*32 +: 32];
    end
    return acc;
  endfunction

  // One MISR step: shift left, conditionally apply the polynomial, mix in data.
  function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                            input logic [31:0] data);
    return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ data;
  endfunction

endpackage

// File: rtl/fuzz_vector_sequencer_if.sv
// Host vector stream and DUT drive/observe bus of the fuzz vector sequencer.
// master = host/harness side, slave = sequencer side.
interface fuzz_vector_sequencer_if #(
  parameter int IN_W  = 62,
  parameter int OUT_W = 192
);

  logic             vec_valid;
  logic [IN_W-1:0]  vec_data;
  logic             vec_last;
  logic             vec_ready;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;

  modport master (
    output vec_valid, vec_data, vec_last, dut_out,
    input  vec_ready, dut_in
  );

  modport slave (
    input  vec_valid, vec_data, vec_last, dut_out,
    output vec_ready, dut_in
  );

endinterface

// File: rtl/fuzz_seq_fifo.sv
// Synchronous FIFO with registered full/empty flags. A push is refused while
// full_q is set even if a pop happens in the same cycle, so the full flag seen
// by the host is always a clean flop output.
module fuzz_seq_fifo #(
  parameter int WIDTH = 63,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push, pop;

  assign push    = wr_en && !full_q;
  assign pop     = rd_en && !empty_q;
  assign full    = full_q;
  assign empty   = empty_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Pointer, occupancy and flag next-state; flags derive from the next count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  // Control state registers; reset empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/fuzz_vector_sequencer.sv
// Fuzz vector sequencer: buffers host vectors, applies each to the DUT input
// bus for HOLD_CYC cycles, samples the DUT output at the end of each hold and
// compresses the samples into a 32-bit MISR signature.
// Optional macro FUZZ_SEQ_OBS_EN adds obs_valid/obs_data, a one-cycle pulse
// carrying each sampled dut_out value.
module fuzz_vector_sequencer
  import fuzz_seq_pkg::*;
#(
  parameter int IN_W     = 62,
  parameter int OUT_W    = 192,
  parameter int DEPTH    = 16,
  parameter int HOLD_CYC = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  fuzz_vector_sequencer_if.slave  bus,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             vec_count,
  output logic [31:0]             signature
`ifdef FUZZ_SEQ_OBS_EN
  ,
  output logic                    obs_valid,
  output logic [OUT_W-1:0]        obs_data
`endif
);

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  seq_state_e       state_q, state_d;
  logic [IN_W-1:0]  dut_in_q, dut_in_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [31:0]      sig_q, sig_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             load;
  logic             capture;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [IN_W:0]    fifo_rd;

  fuzz_seq_fifo #(
    .WIDTH (IN_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.vec_valid),
    .wr_data ({bus.vec_last, bus.vec_data}),
    .full    (fifo_full),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd),
    .empty   (fifo_empty)
  );

  assign bus.vec_ready = !fifo_full;
  assign bus.dut_in    = dut_in_q;
  assign busy          = (state_q == RUN) || (state_q == WAIT);
  assign done          = (state_q == DONE);
  assign vec_count     = cnt_q;
  assign signature     = sig_q;

  // Next-state logic: start handling, hold counting, capture and vector loads.
  always_comb begin
    state_d  = state_q;
    dut_in_d = dut_in_q;
    last_d   = last_q;
    hold_d   = hold_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    capture  = 1'b0;
    fifo_pop = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sig_d = MISR_SEED;
          cnt_d = '0;
          if (!fifo_empty) load = 1'b1;
          else             state_d = WAIT;
        end
      end
      RUN: begin
        if (hold_q == HOLD_LAST) begin
          capture = 1'b1;
          sig_d   = misr_step(sig_q, fold(FOLD_MAX_W'(bus.dut_out)));
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (last_q)           state_d = DONE;
          else if (!fifo_empty) load = 1'b1;
          else                  state_d = WAIT;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      WAIT: begin
        if (!fifo_empty) load = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      fifo_pop = 1'b1;
      dut_in_d = fifo_rd[IN_W-1:0];
      last_d   = fifo_rd[IN_W];
      hold_d   = '0;
      state_d  = RUN;
    end
  end

  // Sequencer state registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      dut_in_q <= '0;
      last_q   <= 1'b0;
      hold_q   <= '0;
      sig_q    <= MISR_SEED;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dut_in_q <= dut_in_d;
      last_q   <= last_d;
      hold_q   <= hold_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef FUZZ_SEQ_OBS_EN
  logic             obs_valid_q, obs_valid_d;
  logic [OUT_W-1:0] obs_data_q, obs_data_d;

  assign obs_valid = obs_valid_q;
  assign obs_data  = obs_data_q;

  // Trace output: one-cycle pulse carrying each captured dut_out sample.
  always_comb begin
    obs_valid_d = capture;
    obs_data_d  = obs_data_q;
    if (capture) obs_data_d = bus.dut_out;
  end

  // Trace output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obs_valid_q <= 1'b0;
      obs_data_q  <= '0;
    end else begin
      obs_valid_q <= obs_valid_d;
      obs_data_q  <= obs_data_d;
    end
  end
`endif

endmodule

// File: tb/tb_fuzz_vector_sequencer.sv
// Directed testbench for fuzz_vector_sequencer. Instance A uses HOLD_CYC=1,
// instance B uses HOLD_CYC=2. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_fuzz_vector_sequencer;

  localparam int IN_W  = 62;
  localparam int OUT_W = 192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        busy_a, done_a, busy_b, done_b;
  logic [15:0] cnt_a, cnt_b;
  logic [31:0] sig_a, sig_b;
  logic        a_mode = 1'b0;
  logic [OUT_W-1:0] a_const = '0;

  int checks   = 0;
  int failures = 0;

  logic [IN_W-1:0] vb [4];
  logic [31:0]     exp_sig;

  fuzz_vector_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) ifa ();
  fuzz_vector_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) ifb ();

`ifdef FUZZ_SEQ_OBS_EN
  logic             obs_valid_a, obs_valid_b;
  logic [OUT_W-1:0] obs_data_a, obs_data_b;
  int               obs_cnt_a;
`endif

  always #5 clk = ~clk;

  // Stand-in DUT response: a fixed function of the applied inputs.
  function automatic logic [OUT_W-1:0] resp(input logic [IN_W-1:0] x);
    return {x, ~x, x, 6'h2A};
  endfunction

  // Reference MISR step written from the signature definition.
  function automatic logic [31:0] model_sig(input logic [31:0] s,
                                            input logic [OUT_W-1:0] y);
    logic [31:0] f;
    logic        fb;
    logic [31:0] r;
    f = 32'h0;
    for (int i = 0; i < OUT_W / 32; i++) f = f ^ y[32*i +: 32];
    fb = s[31];
    r  = s << 1;
    if (fb) r = r ^ 32'h04C1_1DB7;
    return r ^ f;
  endfunction

  function automatic logic [IN_W-1:0] vf(input int k);
    logic [63:0] t;
    t = 64'h9E37_79B9_7F4A_7C15 * 64'(k + 1);
    return t[IN_W-1:0];
  endfunction

  assign ifa.dut_out = a_mode ? resp(ifa.dut_in) : a_const;
  assign ifb.dut_out = resp(ifb.dut_in);

  fuzz_vector_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(16), .HOLD_CYC(1)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .start     (start_a),
    .bus       (ifa.slave),
    .busy      (busy_a),
    .done      (done_a),
    .vec_count (cnt_a),
    .signature (sig_a)
`ifdef FUZZ_SEQ_OBS_EN
    ,
    .obs_valid (obs_valid_a),
    .obs_data  (obs_data_a)
`endif
  );

  fuzz_vector_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(16), .HOLD_CYC(2)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .start     (start_b),
    .bus       (ifb.slave),
    .busy      (busy_b),
    .done      (done_b),
    .vec_count (cnt_b),
    .signature (sig_b)
`ifdef FUZZ_SEQ_OBS_EN
    ,
    .obs_valid (obs_valid_b),
    .obs_data  (obs_data_b)
`endif
  );

`ifdef FUZZ_SEQ_OBS_EN
  // Counts obs_valid pulses of instance A since the last reset.
  always @(posedge clk or posedge rst) begin
    if (rst) obs_cnt_a <= 0;
    else if (obs_valid_a) obs_cnt_a <= obs_cnt_a + 1;
  end
`endif

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_a(input logic [IN_W-1:0] d, input logic l);
    ifa.vec_valid = 1'b1;
    ifa.vec_data  = d;
    ifa.vec_last  = l;
    tick();
    ifa.vec_valid = 1'b0;
  endtask

  task automatic push_b(input logic [IN_W-1:0] d, input logic l);
    ifb.vec_valid = 1'b1;
    ifb.vec_data  = d;
    ifb.vec_last  = l;
    tick();
    ifb.vec_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (ifa.dut_in !== '0) begin failures++; $display("[TB] FAIL reset_dut_in got=%h want=0", ifa.dut_in); end
    checks++; if (sig_a !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL reset_sig got=%h want=ffffffff", sig_a); end
    checks++; if (cnt_a !== 16'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d want=0", cnt_a); end
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_done got=%b%b want=00", busy_a, done_a); end
    checks++; if (ifa.vec_ready !== 1'b1 || ifb.vec_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b%b want=11", ifa.vec_ready, ifb.vec_ready); end
    rst = 1'b0;
    tick();
    checks++; if (busy_a !== 1'b0 || ifa.dut_in !== '0) begin failures++; $display("[TB] FAIL idle_hold got busy=%b dut_in=%h want busy=0 dut_in=0", busy_a, ifa.dut_in); end
  endtask

  task automatic test_single_zero();
    a_mode  = 1'b0;
    a_const = '0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++; if (busy_a !== 1'b1 || done_a !== 1'b0 || ifa.dut_in !== '0) begin failures++; $display("[TB] FAIL wait_entry got busy=%b done=%b dut_in=%h want 1 0 0", busy_a, done_a, ifa.dut_in); end
    push_a(vf(100), 1'b1);
    checks++; if (ifa.dut_in !== '0) begin failures++; $display("[TB] FAIL wait_no_early_pop got=%h want=0", ifa.dut_in); end
    tick();
    checks++; if (ifa.dut_in !== vf(100) || done_a !== 1'b0) begin failures++; $display("[TB] FAIL zero_apply got dut_in=%h done=%b want %h 0", ifa.dut_in, done_a, vf(100)); end
    tick();
    checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) begin failures++; $display("[TB] FAIL zero_done got done=%b busy=%b want 1 0", done_a, busy_a); end
    checks++; if (cnt_a !== 16'd1) begin failures++; $display("[TB] FAIL zero_count got=%0d want=1", cnt_a); end
    checks++; if (sig_a !== 32'hFB3E_E249) begin failures++; $display("[TB] FAIL zero_sig got=%h want=fb3ee249", sig_a); end
  endtask

  task automatic test_single_one();
    a_const = 192'h1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++; if (sig_a !== 32'hFFFF_FFFF || cnt_a !== 16'd0 || busy_a !== 1'b1) begin failures++; $display("[TB] FAIL restart_clear got sig=%h cnt=%0d busy=%b want ffffffff 0 1", sig_a, cnt_a, busy_a); end
    push_a(vf(101), 1'b1);
    tick();
    tick();
    checks++; if (done_a !== 1'b1 || ifa.dut_in !== vf(101)) begin failures++; $display("[TB] FAIL one_done got done=%b dut_in=%h want 1 %h", done_a, ifa.dut_in, vf(101)); end
    checks++; if (sig_a !== 32'hFB3E_E248) begin failures++; $display("[TB] FAIL one_sig got=%h want=fb3ee248", sig_a); end
  endtask

  task automatic test_hold2();
    for (int i = 0; i < 4; i++) begin
      vb[i] = vf(200 + i);
      push_b(vb[i], i == 3);
    end
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (ifb.dut_in !== vb[k/2] || done_b !== 1'b0) begin failures++; $display("[TB] FAIL hold2_cycle%0d got dut_in=%h done=%b want %h 0", k, ifb.dut_in, done_b, vb[k/2]); end
      tick();
    end
    exp_sig = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) exp_sig = model_sig(exp_sig, resp(vb[i]));
    checks++; if (done_b !== 1'b1 || cnt_b !== 16'd4) begin failures++; $display("[TB] FAIL hold2_done got done=%b cnt=%0d want 1 4", done_b, cnt_b); end
    checks++; if (sig_b !== exp_sig) begin failures++; $display("[TB] FAIL hold2_sig got=%h want=%h", sig_b, exp_sig); end
`ifdef FUZZ_SEQ_OBS_EN
    checks++; if (obs_valid_b !== 1'b1 || obs_data_b !== resp(vb[3])) begin failures++; $display("[TB] FAIL hold2_obs got v=%b d=%h want 1 %h", obs_valid_b, obs_data_b, resp(vb[3])); end
`endif
  endtask

  task automatic test_full();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 17; i++) begin
      checks++; if (ifa.vec_ready !== (i < 16)) begin failures++; $display("[TB] FAIL full_ready%0d got=%b want=%b", i, ifa.vec_ready, (i < 16)); end
      ifa.vec_valid = 1'b1;
      ifa.vec_data  = vf(i);
      ifa.vec_last  = (i == 15);
      tick();
    end
    ifa.vec_valid = 1'b0;
    checks++; if (ifa.vec_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready_hold got=%b want=0", ifa.vec_ready); end
    a_mode  = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int n = 0; n < 60 && !done_a; n++) tick();
    exp_sig = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) exp_sig = model_sig(exp_sig, resp(vf(i)));
    checks++; if (done_a !== 1'b1) begin failures++; $display("[TB] FAIL full_timeout got done=%b want=1", done_a); end
    checks++; if (cnt_a !== 16'd16 || ifa.dut_in !== vf(15)) begin failures++; $display("[TB] FAIL full_count got cnt=%0d dut_in=%h want 16 %h", cnt_a, ifa.dut_in, vf(15)); end
    checks++; if (sig_a !== exp_sig) begin failures++; $display("[TB] FAIL full_sig got=%h want=%h", sig_a, exp_sig); end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    checks++; if (busy_a !== 1'b1 || cnt_a !== 16'd0 || ifa.dut_in !== vf(15)) begin failures++; $display("[TB] FAIL full_17th_dropped got busy=%b cnt=%0d dut_in=%h want 1 0 %h", busy_a, cnt_a, ifa.dut_in, vf(15)); end
  endtask

  task automatic test_underflow();
    push_a(vf(300), 1'b0);
    checks++; if (ifa.dut_in !== vf(15)) begin failures++; $display("[TB] FAIL uf_pre got=%h want=%h", ifa.dut_in, vf(15)); end
    tick();
    checks++; if (ifa.dut_in !== vf(300) || cnt_a !== 16'd0) begin failures++; $display("[TB] FAIL uf_apply got dut_in=%h cnt=%0d want %h 0", ifa.dut_in, cnt_a, vf(300)); end
    tick();
    checks++; if (cnt_a !== 16'd1 || busy_a !== 1'b1 || done_a !== 1'b0) begin failures++; $display("[TB] FAIL uf_capture got cnt=%0d busy=%b done=%b want 1 1 0", cnt_a, busy_a, done_a); end
    for (int g = 0; g < 5; g++) begin
      tick();
      checks++; if (ifa.dut_in !== vf(300) || cnt_a !== 16'd1 || busy_a !== 1'b1) begin failures++; $display("[TB] FAIL uf_gap%0d got dut_in=%h cnt=%0d busy=%b want %h 1 1", g, ifa.dut_in, cnt_a, busy_a, vf(300)); end
    end
    push_a(vf(301), 1'b1);
    tick();
    checks++; if (ifa.dut_in !== vf(301) || cnt_a !== 16'd1) begin failures++; $display("[TB] FAIL uf_resume got dut_in=%h cnt=%0d want %h 1", ifa.dut_in, cnt_a, vf(301)); end
    tick();
    exp_sig = model_sig(model_sig(32'hFFFF_FFFF, resp(vf(300))), resp(vf(301)));
    checks++; if (done_a !== 1'b1 || cnt_a !== 16'd2) begin failures++; $display("[TB] FAIL uf_done got done=%b cnt=%0d want 1 2", done_a, cnt_a); end
    checks++; if (sig_a !== exp_sig) begin failures++; $display("[TB] FAIL uf_sig got=%h want=%h", sig_a, exp_sig); end
  endtask

  task automatic test_reset_midrun();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) push_a(vf(400 + i), i == 3);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (busy_a !== 1'b0 || ifa.dut_in !== '0 || cnt_a !== 16'd0 || sig_a !== 32'hFFFF_FFFF || ifa.vec_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrun_reset got busy=%b dut_in=%h cnt=%0d sig=%h ready=%b want 0 0 0 ffffffff 1", busy_a, ifa.dut_in, cnt_a, sig_a, ifa.vec_ready); end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) push_a(vf(400 + i), i == 3);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int n = 0; n < 40 && !done_a; n++) tick();
    exp_sig = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) exp_sig = model_sig(exp_sig, resp(vf(400 + i)));
    checks++; if (done_a !== 1'b1 || cnt_a !== 16'd4) begin failures++; $display("[TB] FAIL midrun_done got done=%b cnt=%0d want 1 4", done_a, cnt_a); end
    checks++; if (sig_a !== exp_sig) begin failures++; $display("[TB] FAIL midrun_sig got=%h want=%h", sig_a, exp_sig); end
`ifdef FUZZ_SEQ_OBS_EN
    checks++; if (obs_valid_a !== 1'b1 || obs_data_a !== resp(vf(403))) begin failures++; $display("[TB] FAIL midrun_obs_data got v=%b d=%h want 1 %h", obs_valid_a, obs_data_a, resp(vf(403))); end
    tick();
    checks++; if (obs_cnt_a !== 32'(cnt_a) || obs_valid_a !== 1'b0) begin failures++; $display("[TB] FAIL midrun_obs_count got pulses=%0d v=%b want %0d 0", obs_cnt_a, obs_valid_a, cnt_a); end
`endif
  endtask

  initial begin
    ifa.vec_valid = 1'b0;
    ifa.vec_data  = '0;
    ifa.vec_last  = 1'b0;
    ifb.vec_valid = 1'b0;
    ifb.vec_data  = '0;
    ifb.vec_last  = 1'b0;
    test_reset();
    test_single_zero();
    test_single_one();
    test_hold2();
    test_full();
    test_underflow();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
